// File: rtl/fb_sched_pkg.sv
// rtl/fb_sched_pkg.sv - shared types and helpers for the triple-buffer frame scheduler
package fb_sched_pkg;

    localparam int NUM_BUF = 3;

    typedef logic [1:0]         buf_idx_t;
    typedef logic [NUM_BUF-1:0] buf_mask_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    // Lowest buffer index whose bit is clear in the exclusion mask.
    function automatic buf_idx_t pick_free(input buf_mask_t excl);
        buf_idx_t pick;
        pick = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (!excl[i]) begin
                pick = buf_idx_t'(i);
            end
        end
        return pick;
    endfunction

    function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input buf_idx_t    idx);
        return base + stride * {30'd0, idx};
    endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// rtl/frame_buffer_scheduler_if.sv - writer/reader event inputs and buffer selection outputs
interface frame_buffer_scheduler_if;
    import fb_sched_pkg::*;

    logic        en;
    logic        wr_frame_done;
    logic        rd_frame_start;
    logic [31:0] wr_base_addr;
    logic [31:0] rd_base_addr;
    buf_idx_t    wr_idx;
    buf_idx_t    rd_idx;
    logic        rd_frame_valid;
    logic        wr_base_update;
    logic [15:0] frames_written;
    logic [15:0] frames_dropped;
    logic [15:0] frames_repeated;

    modport master (
        output en, wr_frame_done, rd_frame_start,
        input  wr_base_addr, rd_base_addr, wr_idx, rd_idx, rd_frame_valid,
        input  wr_base_update, frames_written, frames_dropped, frames_repeated
    );

    modport slave (
        input  en, wr_frame_done, rd_frame_start,
        output wr_base_addr, rd_base_addr, wr_idx, rd_idx, rd_frame_valid,
        output wr_base_update, frames_written, frames_dropped, frames_repeated
    );
endinterface

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit event counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/frame_buffer_scheduler.sv
// rtl/frame_buffer_scheduler.sv - rotates three DDR frame buffers so the writer never
// touches the buffer on screen; counts written, dropped and repeated frames.
module frame_buffer_scheduler
    import fb_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0002_5800
) (
    input logic                     clk_100Mhz,
    input logic                     rst,
    frame_buffer_scheduler_if.slave sched
);
    localparam buf_idx_t WR_RST_IDX = 2'd0;
    localparam buf_idx_t RD_RST_IDX = 2'd2;

    sched_state_t state_q, state_d;
    buf_idx_t     wr_idx_q, wr_idx_d;
    buf_idx_t     rd_idx_q, rd_idx_d;
    buf_idx_t     ready_idx_q, ready_idx_d;
    logic         ready_valid_q, ready_valid_d;
    logic         rd_frame_valid_q, rd_frame_valid_d;
    logic         wr_base_update_q, wr_base_update_d;
    logic [31:0]  wr_addr_q, wr_addr_d;
    logic [31:0]  rd_addr_q, rd_addr_d;
    logic         done_d1_q;

    logic         commit;
    logic         inc_written, inc_dropped, inc_repeated;
    buf_mask_t    wr_mask, rd_mask;

    assign commit  = sched.wr_frame_done & ~done_d1_q;
    assign wr_mask = buf_mask_t'(1) << wr_idx_q;
    assign rd_mask = buf_mask_t'(1) << rd_idx_q;

    always_comb begin
        state_d          = state_q;
        wr_idx_d         = wr_idx_q;
        rd_idx_d         = rd_idx_q;
        ready_idx_d      = ready_idx_q;
        ready_valid_d    = ready_valid_q;
        rd_frame_valid_d = rd_frame_valid_q;
        inc_written      = 1'b0;
        inc_dropped      = 1'b0;
        inc_repeated     = 1'b0;

        if (!sched.en) begin
            state_d          = OFF;
            wr_idx_d         = WR_RST_IDX;
            rd_idx_d         = RD_RST_IDX;
            ready_idx_d      = '0;
            ready_valid_d    = 1'b0;
            rd_frame_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                OFF: state_d = FILL;
                FILL: begin
                    if (commit) begin
                        state_d       = RUN;
                        ready_idx_d   = 2'd0;
                        ready_valid_d = 1'b1;
                        wr_idx_d      = 2'd1;
                        inc_written   = 1'b1;
                    end
                end
                RUN: begin
                    // A simultaneous start displays the frame just committed, skipping ready.
                    if (commit && sched.rd_frame_start) begin
                        rd_idx_d         = wr_idx_q;
                        ready_valid_d    = 1'b0;
                        rd_frame_valid_d = 1'b1;
                        wr_idx_d         = pick_free(wr_mask);
                        inc_dropped      = ready_valid_q;
                        inc_written      = 1'b1;
                    end else if (commit) begin
                        ready_idx_d   = wr_idx_q;
                        ready_valid_d = 1'b1;
                        wr_idx_d      = pick_free(wr_mask | rd_mask);
                        inc_dropped   = ready_valid_q;
                        inc_written   = 1'b1;
                    end else if (sched.rd_frame_start) begin
                        if (ready_valid_q) begin
                            rd_idx_d         = ready_idx_q;
                            ready_valid_d    = 1'b0;
                            rd_frame_valid_d = 1'b1;
                        end else begin
                            inc_repeated = 1'b1;
                        end
                    end
                end
                default: state_d = OFF;
            endcase
        end

        wr_base_update_d = sched.en && (wr_idx_d != wr_idx_q);
        wr_addr_d        = buf_addr(BASE_ADDR, FRAME_STRIDE, wr_idx_d);
        rd_addr_d        = buf_addr(BASE_ADDR, FRAME_STRIDE, rd_idx_d);
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_q          <= OFF;
            wr_idx_q         <= WR_RST_IDX;
            rd_idx_q         <= RD_RST_IDX;
            ready_idx_q      <= '0;
            ready_valid_q    <= 1'b0;
            rd_frame_valid_q <= 1'b0;
            wr_base_update_q <= 1'b0;
            wr_addr_q        <= buf_addr(BASE_ADDR, FRAME_STRIDE, WR_RST_IDX);
            rd_addr_q        <= buf_addr(BASE_ADDR, FRAME_STRIDE, RD_RST_IDX);
            done_d1_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_idx_q         <= wr_idx_d;
            rd_idx_q         <= rd_idx_d;
            ready_idx_q      <= ready_idx_d;
            ready_valid_q    <= ready_valid_d;
            rd_frame_valid_q <= rd_frame_valid_d;
            wr_base_update_q <= wr_base_update_d;
            wr_addr_q        <= wr_addr_d;
            rd_addr_q        <= rd_addr_d;
            done_d1_q        <= sched.wr_frame_done;
        end
    end

    sat_counter16 u_cnt_written (
        .clk   (clk_100Mhz),
        .rst   (rst),
        .inc   (inc_written),
        .count (sched.frames_written)
    );

    sat_counter16 u_cnt_dropped (
        .clk   (clk_100Mhz),
        .rst   (rst),
        .inc   (inc_dropped),
        .count (sched.frames_dropped)
    );

    sat_counter16 u_cnt_repeated (
        .clk   (clk_100Mhz),
        .rst   (rst),
        .inc   (inc_repeated),
        .count (sched.frames_repeated)
    );

    assign sched.wr_idx         = wr_idx_q;
    assign sched.rd_idx         = rd_idx_q;
    assign sched.wr_base_addr   = wr_addr_q;
    assign sched.rd_base_addr   = rd_addr_q;
    assign sched.rd_frame_valid = rd_frame_valid_q;
    assign sched.wr_base_update = wr_base_update_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// tb/tb_frame_buffer_scheduler.sv - bench for frame_buffer_scheduler against a frame-level model
module tb_frame_buffer_scheduler;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0002_5800;

    logic clk;
    logic rst;
    bit   sat_written;
    int   n_vec;
    int   n_err;

    frame_buffer_scheduler_if bus ();

    frame_buffer_scheduler #(
        .BASE_ADDR    (BASE),
        .FRAME_STRIDE (STRIDE)
    ) dut (
        .clk_100Mhz (clk),
        .rst        (rst),
        .sched      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: state 0=off 1=fill 2=run; ready = -1 when nothing is waiting for display.
    typedef struct {
        int state;
        int wr;
        int rd;
        int ready;
        bit fvalid;
        bit upd;
        int written;
        int dropped;
        int repeated;
        bit prev_done;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.state = 0; r.wr = 0; r.rd = 2; r.ready = -1; r.fvalid = 0; r.upd = 0;
        r.written = 0; r.dropped = 0; r.repeated = 0; r.prev_done = 0;
        return r;
    endfunction

    function automatic int lowest_free(int a, int b);
        for (int i = 0; i < 3; i++) begin
            if (i != a && i != b) return i;
        end
        return 0;
    endfunction

    function automatic model_t model_step(model_t s, bit en_v, bit done_v, bit start_v);
        model_t n;
        bit commit;
        n = s;
        commit = done_v && !s.prev_done;
        n.prev_done = done_v;
        n.upd = 0;
        if (!en_v) begin
            n.state = 0; n.wr = 0; n.rd = 2; n.ready = -1; n.fvalid = 0;
            return n;
        end
        case (s.state)
            0: n.state = 1;
            1: if (commit) begin
                n.state = 2; n.ready = 0; n.wr = 1; n.written += 1;
            end
            default: begin
                if (commit) begin
                    n.written += 1;
                    if (s.ready >= 0) n.dropped += 1;
                end
                if (commit && start_v) begin
                    n.rd = s.wr; n.ready = -1; n.fvalid = 1; n.wr = lowest_free(s.wr, s.wr);
                end else if (commit) begin
                    n.ready = s.wr; n.wr = lowest_free(s.rd, s.wr);
                end else if (start_v) begin
                    if (s.ready >= 0) begin
                        n.rd = s.ready; n.ready = -1; n.fvalid = 1;
                    end else begin
                        n.repeated += 1;
                    end
                end
            end
        endcase
        n.upd = (n.wr != s.wr);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, bus.en, bus.wr_frame_done, bus.rd_frame_start);
    end

    function automatic logic [15:0] sat16(int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [31:0] addr_of(int idx);
        return BASE + STRIDE * 32'(idx);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_w;
        exp_w = sat_written ? 16'hFFFF : sat16(m.written);
        check("wr_idx",          32'(bus.wr_idx),          32'(m.wr));
        check("rd_idx",          32'(bus.rd_idx),          32'(m.rd));
        check("wr_base_addr",    bus.wr_base_addr,         addr_of(m.wr));
        check("rd_base_addr",    bus.rd_base_addr,         addr_of(m.rd));
        check("rd_frame_valid",  32'(bus.rd_frame_valid),  32'(m.fvalid));
        check("wr_base_update",  32'(bus.wr_base_update),  32'(m.upd));
        check("frames_written",  32'(bus.frames_written),  32'(exp_w));
        check("frames_dropped",  32'(bus.frames_dropped),  32'(sat16(m.dropped)));
        check("frames_repeated", 32'(bus.frames_repeated), 32'(sat16(m.repeated)));
        check("wr_ne_rd",        32'(bus.wr_idx != bus.rd_idx), 32'd1);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic commit_pulse();
        bus.wr_frame_done = 1'b1;
        tick();
        bus.wr_frame_done = 1'b0;
    endtask

    task automatic start_pulse();
        bus.rd_frame_start = 1'b1;
        tick();
        bus.rd_frame_start = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sat_written = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.wr_frame_done = 1'b0;
        bus.rd_frame_start = 1'b0;

        repeat (2) tick();
        check("rst_wr_addr", bus.wr_base_addr, 32'h1000_0000);
        check("rst_rd_addr", bus.rd_base_addr, 32'h1004_B000);
        check("rst_rd_idx", 32'(bus.rd_idx), 32'd2);
        rst = 1'b0;
        tick();

        bus.en = 1'b1;
        repeat (2) tick();
        start_pulse();
        check("fill_ignores_start", 32'(bus.frames_repeated), 32'd0);

        commit_pulse();
        check("first_commit_wr_idx", 32'(bus.wr_idx), 32'd1);
        check("first_commit_addr", bus.wr_base_addr, 32'h1002_5800);
        check("first_commit_upd", 32'(bus.wr_base_update), 32'd1);
        check("first_commit_written", 32'(bus.frames_written), 32'd1);
        check("first_commit_rvalid", 32'(bus.rd_frame_valid), 32'd0);
        tick();
        check("upd_one_cycle", 32'(bus.wr_base_update), 32'd0);

        start_pulse();
        check("start_rd_idx", 32'(bus.rd_idx), 32'd0);
        check("start_rd_addr", bus.rd_base_addr, 32'h1000_0000);
        check("start_rvalid", 32'(bus.rd_frame_valid), 32'd1);
        tick();
        start_pulse();
        check("repeat_count", 32'(bus.frames_repeated), 32'd1);
        tick();

        commit_pulse();
        check("commit2_wr_idx", 32'(bus.wr_idx), 32'd2);
        tick();
        commit_pulse();
        check("commit3_wr_idx", 32'(bus.wr_idx), 32'd1);
        check("commit3_dropped", 32'(bus.frames_dropped), 32'd1);
        tick();

        bus.en = 1'b0;
        tick();
        check("en_off_written_kept", 32'(bus.frames_written), 32'd3);
        check("en_off_wr_addr", bus.wr_base_addr, 32'h1000_0000);
        check("en_off_rd_addr", bus.rd_base_addr, 32'h1004_B000);
        check("en_off_no_upd", 32'(bus.wr_base_update), 32'd0);
        tick();

        bus.en = 1'b1;
        repeat (2) tick();
        commit_pulse();
        tick();
        start_pulse();
        tick();

        bus.wr_frame_done = 1'b1;
        bus.rd_frame_start = 1'b1;
        tick();
        bus.wr_frame_done = 1'b0;
        bus.rd_frame_start = 1'b0;
        check("both_rd_idx", 32'(bus.rd_idx), 32'd1);
        check("both_wr_idx", 32'(bus.wr_idx), 32'd0);
        check("both_rvalid", 32'(bus.rd_frame_valid), 32'd1);
        check("both_no_drop", 32'(bus.frames_dropped), 32'd1);
        tick();

        bus.wr_frame_done = 1'b1;
        repeat (100) tick();
        bus.wr_frame_done = 1'b0;
        check("held_done_once", 32'(bus.frames_written), 32'd6);
        tick();

        bus.rd_frame_start = 1'b1;
        repeat (2) tick();
        bus.rd_frame_start = 1'b0;
        tick();

        force dut.u_cnt_written.count_q = 16'hFFFF;
        sat_written = 1;
        tick();
        release dut.u_cnt_written.count_q;
        tick();
        commit_pulse();
        check("written_saturates", 32'(bus.frames_written), 32'h0000_FFFF);
        tick();

        bus.en = 1'b0;
        tick();
        check("en_off_sat_kept", 32'(bus.frames_written), 32'h0000_FFFF);
        #2;
        rst = 1'b1;
        sat_written = 0;
        #1;
        check("async_rst_written", 32'(bus.frames_written), 32'd0);
        check("async_rst_repeated", 32'(bus.frames_repeated), 32'd0);
        check("async_rst_wr_addr", bus.wr_base_addr, 32'h1000_0000);
        check("async_rst_rd_addr", bus.rd_base_addr, 32'h1004_B000);
        check("async_rst_rvalid", 32'(bus.rd_frame_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Triple-buffer scheduler for the camera-to-DDR-to-HDMI frame path, running in the clk_100Mhz domain. It gives the AXI4 stream-to-memory writer a stable frame base address and gives the HDMI read path a stable display address. On each committed write frame and each display frame start it rotates three DDR frame buffers, so the writer never overwrites the frame being displayed. It also reports dropped and repeated frames.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, DDR address of buffer 0
- FRAME_STRIDE, 32'h0002_5800, bytes between buffers (320x240x2)

Ports:
- clk_100Mhz  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scheduler enable, level
- wr_frame_done  in  1  writer frame-complete level from the writer; rising edge = frame committed to DDR
- rd_frame_start  in  1  1-cycle pulse from the HDMI reader at the start of each output frame
- wr_base_addr  out  32  frame base for the writer
- rd_base_addr  out  32  frame base for the display reader
- wr_idx  out  2  buffer index being written
- rd_idx  out  2  buffer index being displayed
- rd_frame_valid  out  1  rd_base_addr holds a completed frame; reader outputs black while 0
- wr_base_update  out  1  1-cycle pulse, same cycle wr_base_addr takes a new value
- frames_written  out  16  commits counted, saturating
- frames_dropped  out  16  committed frames overwritten before display, saturating
- frames_repeated  out  16  display frames reusing the previous buffer, saturating

## Operation
Reset values:
- state OFF, wr_idx 0, rd_idx 2, ready_valid 0
- wr_base_addr BASE_ADDR, rd_base_addr BASE_ADDR+2*FRAME_STRIDE
- rd_frame_valid 0, wr_base_update 0, all counters 0

Definitions:
- Internal state: ready_idx (last committed buffer) and ready_valid.
- commit = wr_frame_done & ~wr_frame_done_d1. The d1 register resets to 0.
- Address = BASE_ADDR + idx*FRAME_STRIDE, computed modulo 2^32 and registered.

States:
- OFF: outputs held at reset values except counters. en=1 -> FILL.
- FILL: writer fills wr_idx 0. rd_frame_start is ignored. A commit sets ready_idx=0, ready_valid=1, wr_idx=1, frames_written+1, and moves to RUN.
- RUN, commit only:
  - ready_idx=wr_idx, ready_valid=1.
  - If ready_valid was already 1, frames_dropped+1.
  - wr_idx = lowest index not in {rd_idx, new ready_idx}.
  - frames_written+1.
- RUN, rd_frame_start only:
  - If ready_valid=1: rd_idx=ready_idx, ready_valid=0, rd_frame_valid=1.
  - Otherwise frames_repeated+1 and rd_idx is unchanged.
- RUN, both in the same cycle:
  - rd_idx=old wr_idx, ready_valid=0, rd_frame_valid=1.
  - wr_idx = lowest index not equal to old wr_idx.
  - If ready_valid was 1, frames_dropped+1.
  - frames_written+1.
- Any state with en=0: -> OFF next cycle. Indices and addresses return to reset values; counters are kept.

Invariant: wr_idx != rd_idx in every cycle, and wr_idx != ready_idx whenever ready_valid=1.

## Timing
- An event sampled at edge N has its outputs visible after edge N (1-cycle latency). All outputs are registered.
- wr_base_update pulses exactly when wr_idx changes, including the FILL->RUN transition. It does not pulse on en-driven returns to OFF.
- rd_frame_start pulses spaced 1 cycle apart are each processed.
- A continuously high wr_frame_done yields one commit only.
- An asynchronous rst mid-frame forces reset values immediately.
- Counters stop at 16'hFFFF.

## Structure
- Package fb_sched_pkg holds:
  - NUM_BUF=3
  - the 2-bit buffer index type
  - the state enum OFF/FILL/RUN
  - the free-index pick function (lowest index outside an exclusion set)
  - the address function base+idx*stride
- Sub-module sat_counter16 (clk, rst, inc, count), instantiated three times.

## Test plan
- en=1, one commit -> wr_idx 1, wr_base_addr 0x1002_5800, wr_base_update 1 cycle, frames_written 1, rd_frame_valid 0.
- Then rd_frame_start -> rd_idx 0, rd_base_addr 0x1000_0000, rd_frame_valid 1. A second rd_frame_start with no commit -> frames_repeated 1.
- From wr=1, rd=0, ready invalid: two commits, no starts -> wr_idx 2 then 1, frames_dropped 1, wr_idx never equal to 0.
- From wr=1, rd=0, ready invalid: simultaneous commit and start -> rd_idx 1, wr_idx 0, rd_frame_valid 1, no drop.
- wr_frame_done held high 100 cycles -> frames_written increments once. Counter forced to 16'hFFFF plus a commit -> stays 16'hFFFF.
- en dropped in RUN, then rst asserted mid-cycle -> OFF, wr_base_addr 0x1000_0000, rd_base_addr 0x1004_B000, rd_frame_valid 0. Counters are retained after en drop and zeroed after rst.
